// File: rtl/alu_func_pkg.sv
// rtl/alu_func_pkg.sv - class, operation and function-code constants shared with the ALU control decoder
package alu_func_pkg;

  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_MEM    = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  localparam logic [3:0] OP_LD   = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0001;

  localparam logic [3:0] OP_BEQ  = 4'b0000;
  localparam logic [3:0] OP_BNE  = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;

  // 4'b1111 is reserved on the decoder side and never encoded.
  typedef enum logic [3:0] {
    FN_ADD  = 4'b0000,
    FN_SUB  = 4'b0001,
    FN_AND  = 4'b0010,
    FN_OR   = 4'b0011,
    FN_XOR  = 4'b0100,
    FN_SLT  = 4'b0101,
    FN_SLL  = 4'b0110,
    FN_SRL  = 4'b0111,
    FN_SRA  = 4'b1000,
    FN_SLTU = 4'b1001,
    FN_LD   = 4'b1010,
    FN_ST   = 4'b1011,
    FN_BEQ  = 4'b1100,
    FN_BNE  = 4'b1101,
    FN_JMP  = 4'b1110
  } func_t;

  typedef struct packed {
    logic  legal;
    func_t func;
  } enc_t;

  function automatic enc_t encode(input logic [1:0] fc2, input logic [3:0] fc4);
    enc_t r;
    r.legal = 1'b1;
    r.func  = FN_ADD;
    case (fc2)
      CLS_ALU: begin
        case (fc4)
          OP_ADD:  r.func = FN_ADD;
          OP_SUB:  r.func = FN_SUB;
          OP_AND:  r.func = FN_AND;
          OP_OR:   r.func = FN_OR;
          OP_XOR:  r.func = FN_XOR;
          OP_SLT:  r.func = FN_SLT;
          OP_SLL:  r.func = FN_SLL;
          OP_SRL:  r.func = FN_SRL;
          OP_SRA:  r.func = FN_SRA;
          OP_SLTU: r.func = FN_SLTU;
          default: r.legal = 1'b0;
        endcase
      end
      CLS_MEM: begin
        case (fc4)
          OP_LD:   r.func = FN_LD;
          OP_ST:   r.func = FN_ST;
          default: r.legal = 1'b0;
        endcase
      end
      CLS_BRANCH: begin
        case (fc4)
          OP_BEQ:  r.func = FN_BEQ;
          OP_BNE:  r.func = FN_BNE;
          OP_JMP:  r.func = FN_JMP;
          default: r.legal = 1'b0;
        endcase
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_enc_fifo.sv
// rtl/alu_enc_fifo.sv - DEPTH-entry function-code FIFO with flush and combinational head read
module alu_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Flush wins over both ports; a full FIFO never accepts even if it pops this cycle.
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_func_encoder.sv
// rtl/alu_func_encoder.sv - (class, op) to ALU function-code encoder with output FIFO and error pulse
// Optional saturating illegal-request counter enabled by ALU_FUNC_ENC_ERR_CNT_EN.
module alu_func_encoder
  import alu_func_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_valid,
  output logic       out_ready,
  input  logic [1:0] in_fc2,
  input  logic [3:0] in_fc4,
  input  logic       in_flush,
  output logic       out_valid,
  input  logic       in_ready,
  output logic [3:0] out_func,
  output logic       out_err,
  output logic [7:0] out_err_cnt
);

  enc_t enc;
  logic accept, push, pop;
  logic full, empty;
  logic err_d, err_q;

  assign out_ready = !full;
  assign out_valid = !empty;
  assign out_err   = err_q;

  // Illegal pairs are consumed without a write but still flag, flush or not.
  always_comb begin
    enc    = encode(in_fc2, in_fc4);
    accept = in_valid && out_ready;
    push   = accept && enc.legal;
    pop    = out_valid && in_ready;
    err_d  = accept && !enc.legal;
  end

  alu_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (in_clk),
    .rst   (in_rst),
    .push  (push),
    .wdata (enc.func),
    .pop   (pop),
    .flush (in_flush),
    .rdata (out_func),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) err_q <= 1'b0;
    else        err_q <= err_d;
  end

`ifdef ALU_FUNC_ENC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign out_err_cnt = err_cnt_q;
`else
  assign out_err_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_func_encoder.sv
// tb/tb_alu_func_encoder.sv - directed self-checking bench for alu_func_encoder
module tb_alu_func_encoder;

  localparam int DEPTH = 4;

`ifdef ALU_FUNC_ENC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       in_clk = 1'b0;
  logic       in_rst, in_valid, in_flush, in_ready;
  logic [1:0] in_fc2;
  logic [3:0] in_fc4;
  logic       out_ready, out_valid, out_err;
  logic [3:0] out_func;
  logic [7:0] out_err_cnt;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Legal {fc2,fc4} pairs in table order; entry k encodes to function code k.
  logic [5:0] legal_pair [15] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                  6'h0A, 6'h0B, 6'h10, 6'h11, 6'h20, 6'h21, 6'h22};

  alu_func_encoder #(.DEPTH(DEPTH)) dut (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .in_fc2      (in_fc2),
    .in_fc4      (in_fc4),
    .in_flush    (in_flush),
    .out_valid   (out_valid),
    .in_ready    (in_ready),
    .out_func    (out_func),
    .out_err     (out_err),
    .out_err_cnt (out_err_cnt)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int err_seen;
    int j;
    int code;
    bit lg;
    int exp_q[$];

    in_rst = 1'b1; in_valid = 1'b0; in_flush = 1'b0; in_ready = 1'b1;
    in_fc2 = 2'b00; in_fc4 = 4'h0;
    tick(); tick();
    in_rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_ready", out_ready, 1);
    check("rst_func", out_func, 0);
    check("rst_err", out_err, 0);
    check("rst_cnt", out_err_cnt, 0);
    tick();
    check("rst_ready2", out_ready, 1);

    // Single request: ALU 1011 -> 1001, one cycle latency
    in_valid = 1'b1; in_fc2 = 2'b00; in_fc4 = 4'b1011;
    tick();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_func", out_func, 8'h9);
    check("single_err", out_err, 0);
    tick();
    check("single_drain", out_valid, 0);

    // Sweep all 64 pairs
    k = 0; err_seen = 0;
    for (int c = 0; c < 4; c++) begin
      for (int o = 0; o < 16; o++) begin
        in_valid = 1'b1; in_fc2 = c[1:0]; in_fc4 = o[3:0];
        lg = 1'b0;
        for (int m = 0; m < 15; m++) if (legal_pair[m] == {c[1:0], o[3:0]}) lg = 1'b1;
        tick();
        if (out_err === 1'b1) err_seen++;
        if (lg) begin
          check("sweep_func", out_func, 8'(k));
          check("sweep_valid", out_valid, 1);
          check("sweep_err0", out_err, 0);
          k++;
        end else begin
          check("sweep_err1", out_err, 1);
          check("sweep_nowrite", out_valid, 0);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    check("sweep_pulses", 8'(err_seen), 8'd49);
    check("sweep_err_single", out_err, 0);
    check("sweep_idle", out_valid, 0);
    check("sweep_cnt", out_err_cnt, CNT_EN ? 8'd49 : 8'd0);

    // Stall: 5 pushes into a 4-deep FIFO
    in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_fc2 = 2'b00; in_fc4 = i[3:0];
      tick();
      check("stall_ready", out_ready, (i < 3) ? 8'd1 : 8'd0);
      check("stall_head", out_func, 0);
      check("stall_valid", out_valid, 1);
    end
    in_valid = 1'b0; in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_func", out_func, 8'(i));
      check("drain_valid", out_valid, 1);
      tick();
      if (i == 0) check("ready_after_pop", out_ready, 1);
    end
    check("drain_empty", out_valid, 0);

    // Continuous push/pop at occupancy 2 across pointer wrap
    in_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; {in_fc2, in_fc4} = legal_pair[i + 10];
      exp_q.push_back(i + 10);
      tick();
    end
    in_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      j = (i * 7) % 15;
      {in_fc2, in_fc4} = legal_pair[j];
      code = exp_q.pop_front();
      check("stream_func", out_func, 8'(code));
      tick();
      exp_q.push_back(j);
      check("stream_valid", out_valid, 1);
      check("stream_ready", out_ready, 1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      code = exp_q.pop_front();
      check("stream_tail", out_func, 8'(code));
      tick();
    end
    check("stream_empty", out_valid, 0);

    // Flush with 3 buffered and a simultaneous legal push
    in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; {in_fc2, in_fc4} = legal_pair[i + 10];
      tick();
    end
    check("preflush_head", out_func, 8'hA);
    in_flush = 1'b1; in_valid = 1'b1; {in_fc2, in_fc4} = legal_pair[13];
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_ready", out_ready, 1);
    check("flush_err0", out_err, 0);
    in_flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
    tick();
    check("flush_no_emit", out_valid, 0);
    in_flush = 1'b1; in_valid = 1'b1; in_fc2 = 2'b11; in_fc4 = 4'h0;
    tick();
    check("flush_illegal_err", out_err, 1);
    check("flush_illegal_valid", out_valid, 0);
    in_flush = 1'b0; in_fc2 = 2'b00; in_fc4 = 4'b0101;
    tick();
    in_valid = 1'b0;
    check("postflush_err", out_err, 0);
    check("postflush_valid", out_valid, 1);
    check("postflush_func", out_func, 8'h5);
    tick();
    check("postflush_empty", out_valid, 0);

    // 300 back-to-back illegal requests
    in_valid = 1'b1; in_fc2 = 2'b11; in_fc4 = 4'hF;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i < 3) check("b2b_err", out_err, 1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("cnt_sat", out_err_cnt, CNT_EN ? 8'd255 : 8'd0);
    check("b2b_end", out_err, 0);
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    check("rst2_cnt", out_err_cnt, 0);
    check("rst2_valid", out_valid, 0);
    check("rst2_ready", out_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
